// File: rtl/lbist_tpg_pkg.sv
// Shared constants and phase-shifter tap formula for the LBIST pattern generator.
// The bench model reuses phase_shift().
package lbist_pkg;

    localparam int unsigned DOUT_W = 267;
    localparam int unsigned LFSR_W = 32;
    localparam int unsigned S_IW   = $clog2(LFSR_W);
    localparam int unsigned D_IW   = $clog2(DOUT_W);
    localparam logic [LFSR_W-1:0] POLY = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] SEED = 32'h0000_0001;

    // Three taps per output; for LFSR_W=32 they are always distinct, so no tap cancels.
    function automatic logic [DOUT_W-1:0] phase_shift(input logic [LFSR_W-1:0] s);
        logic [DOUT_W-1:0] d;
        logic [S_IW-1:0]   a;
        logic [S_IW-1:0]   b;
        logic [S_IW-1:0]   c;
        d = '0;
        for (int unsigned i = 0; i < DOUT_W; i++) begin
            a = S_IW'(i % LFSR_W);
            b = S_IW'((7 * i + 3) % LFSR_W);
            c = S_IW'((11 * i + 5) % LFSR_W);
            d[D_IW'(i)] = s[a] ^ s[b] ^ s[c];
        end
        return d;
    endfunction

endpackage

// File: rtl/lbist_tpg_if.sv
// Pattern-generator control/data bundle: enable in, pseudo-random pattern out.
interface lbist_tpg_if;
    import lbist_pkg::*;

    logic              en;
    logic [DOUT_W-1:0] dout;

    modport master (output en, input dout);
    modport slave  (input en, output dout);

endinterface

// File: rtl/lbist_lfsr.sv
// 32-bit Galois LFSR with enable, async reset to SEED and all-zero lock-up recovery.
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int unsigned       W     = LFSR_W,
    parameter logic [W-1:0]      P     = POLY,
    parameter logic [W-1:0]      S0    = SEED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] s_q;
    logic [W-1:0] s_d;

    // Zero state is only reachable through a fault; recover even when disabled.
    always_comb begin
        s_d = s_q;
        if (s_q == '0) begin
            s_d = S0;
        end else if (en_i) begin
            s_d = s_q[0] ? ((s_q >> 1) ^ P) : (s_q >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= S0;
        end else begin
            s_q <= s_d;
        end
    end

    assign state_o = s_q;

endmodule

// File: rtl/lbist_tpg.sv
// LBIST test-pattern generator: LFSR state expanded by a fixed XOR3 phase shifter.
module lbist_tpg
    import lbist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    lbist_tpg_if.slave  bus
);

    logic [LFSR_W-1:0] s;

    lbist_lfsr #(
        .W  (LFSR_W),
        .P  (POLY),
        .S0 (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.en),
        .state_o (s)
    );

    for (genvar i = 0; i < DOUT_W; i++) begin : g_ps
        localparam logic [S_IW-1:0] TA = S_IW'(i % LFSR_W);
        localparam logic [S_IW-1:0] TB = S_IW'((7 * i + 3) % LFSR_W);
        localparam logic [S_IW-1:0] TC = S_IW'((11 * i + 5) % LFSR_W);
        assign bus.dout[i] = s[TA] ^ s[TB] ^ s[TC];
    end

endmodule

// File: tb/tb_lbist_tpg.sv
// Self-checking bench for lbist_tpg: per-cycle model compare plus directed vectors.
module tb_lbist_tpg;
    import lbist_pkg::*;

    localparam int unsigned NLONG = 20000;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic done = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [LFSR_W-1:0] m_s = SEED;

    lbist_tpg_if bus ();

    lbist_tpg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 if (!done) clk = ~clk;

    function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] s);
        if (s % 2 == 1) return (s / 2) ^ POLY;
        return s / 2;
    endfunction

    // Bit i is set when an odd number of its three taps are set.
    function automatic logic [DOUT_W-1:0] pattern(input logic [LFSR_W-1:0] s);
        logic [DOUT_W-1:0] d;
        int n;
        d = '0;
        for (int i = 0; i < int'(DOUT_W); i++) begin
            n = 0;
            if (s[i % 32])            n++;
            if (s[(7 * i + 3) % 32])  n++;
            if (s[(11 * i + 5) % 32]) n++;
            d[i] = (n % 2 == 1);
        end
        return d;
    endfunction

    function automatic logic [DOUT_W-1:0] reset_pattern();
        logic [DOUT_W-1:0] d;
        d = '0;
        for (int i = 0; i < int'(DOUT_W); i++)
            if ((i % 32 == 0) || (i % 32 == 17) || (i % 32 == 27)) d[i] = 1'b1;
        return d;
    endfunction

    task automatic chk(input string name, input logic [DOUT_W-1:0] act, input logic [DOUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst)         m_s = SEED;
        else if (bus.en) m_s = step(m_s);
    end

    always @(negedge clk) begin
        chk("dout_cycle", bus.dout, pattern(m_s));
        chk32("state_cycle", dut.u_lfsr.s_q, m_s);
    end

    task automatic seq_check(input string tag);
        @(posedge clk); #1;
        chk32({tag, "_s1"}, dut.u_lfsr.s_q, 32'h8020_0003);
        chk32({tag, "_m1"}, m_s, 32'h8020_0003);
        @(posedge clk); #1;
        chk32({tag, "_s2"}, dut.u_lfsr.s_q, 32'hC030_0002);
        @(posedge clk); #1;
        chk32({tag, "_s3"}, dut.u_lfsr.s_q, 32'h6018_0001);
        chk32({tag, "_m3"}, m_s, 32'h6018_0001);
        chk({tag, "_d3"}, bus.dout, pattern(32'h6018_0001));
    endtask

    logic [LFSR_W-1:0] held;
    logic [LFSR_W-1:0] cur;
    bit                seen [logic [31:0]];
    int                ones [DOUT_W];
    int                zeros_seen;
    int                repeats;
    int                bad_density;
    logic [DOUT_W-1:0] oh_exp;
    logic [LFSR_W-1:0] oh;

    initial begin
        bus.en = 1'b0;
        #1 rst = 1'b1;

        // Reset holds regardless of en
        repeat (4) begin
            @(posedge clk); #1;
            chk32("rst_state", dut.u_lfsr.s_q, 32'h0000_0001);
            chk("rst_dout", bus.dout, reset_pattern());
            bus.en = ~bus.en;
        end
        chki("rst_ones", $countones(bus.dout), 25);
        chki("rst_bit32", int'(bus.dout[32]), 1);
        chki("rst_bit1", int'(bus.dout[1]), 0);

        bus.en = 1'b1;
        rst = 1'b0;
        seq_check("seq");

        // Run to step 100, then hold for 10 edges
        repeat (97) @(posedge clk);
        #1;
        held = m_s;
        bus.en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk32("hold_state", dut.u_lfsr.s_q, held);
        chk("hold_dout", bus.dout, pattern(held));
        bus.en = 1'b1;
        @(posedge clk); #1;
        chk32("resume_state", dut.u_lfsr.s_q, step(held));

        // Async reset between edges
        #2 rst = 1'b1;
        #1;
        chk32("async_state", dut.u_lfsr.s_q, 32'h0000_0001);
        chk("async_dout", bus.dout, reset_pattern());
        @(posedge clk); #1;
        rst = 1'b0;
        seq_check("restart");

        // Long run
        zeros_seen = 0;
        repeats = 0;
        for (int i = 0; i < int'(DOUT_W); i++) ones[i] = 0;
        repeat (NLONG) begin
            @(posedge clk); #1;
            cur = dut.u_lfsr.s_q;
            if (cur == '0) zeros_seen++;
            if (seen.exists(cur)) repeats++;
            seen[cur] = 1'b1;
            for (int i = 0; i < int'(DOUT_W); i++) ones[i] += int'(bus.dout[i]);
        end
        bad_density = 0;
        for (int i = 0; i < int'(DOUT_W); i++)
            if (ones[i] * 100 < int'(NLONG) * 47 || ones[i] * 100 > int'(NLONG) * 53) bad_density++;
        chki("long_zero_states", zeros_seen, 0);
        chki("long_repeats", repeats, 0);
        chki("long_density", bad_density, 0);

        // One-hot tap wiring: each output bit hit by exactly one tap
        for (int b = 0; b < 32; b++) begin
            oh = '0;
            oh[b] = 1'b1;
            oh_exp = '0;
            for (int i = 0; i < int'(DOUT_W); i++)
                if ((i % 32 == b) || ((7 * i + 3) % 32 == b) || ((11 * i + 5) % 32 == b)) oh_exp[i] = 1'b1;
            chk("tap_model", pattern(oh), oh_exp);
            chk("tap_pkg", phase_shift(oh), oh_exp);
        end

        done = 1'b1;
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
